uart_trx_param: RTL and testbench

Parametrised full-duplex UART transceiver, the next generation of the fixed 8-bit Tx/Rx pair. Adds a configurable data width, runtime parity mode (none/even/odd) and 1 or 2 stop bits. The receiver uses 16x oversampling with a 3-sample majority vote and rejects glitches. An internal loopback mux allows self-test. Sits between the host datapath and the board serial pins.

---
 rtl/uart_pkg.sv | 61 ++++++
 rtl/uart_trx_param_baud_gen.sv | 44 ++++
 rtl/uart_trx_param.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, baud table and divider helpers
// for the parametrised UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int unsigned baud_rate(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Cycles per 16x oversampling tick, rounded to nearest.
  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input logic [2:0]  sel
  );
    int unsigned b16;
    b16 = 16 * baud_rate(sel);
    return (clk_hz + b16 / 2) / b16;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_trx_param_baud_gen.sv
// uart_baud_gen: 16x oversampling tick generator.
// Ports: clk, reset, sel (baud select) -> tick (1-cycle pulse).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sel,
  output logic       tick
);

  localparam int unsigned DIV_MAX = baud_div(CLK_HZ, 3'd0);
  localparam int unsigned CNT_W = $clog2(DIV_MAX + 1);

  logic [CNT_W-1:0] div_tab [8];
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic             wrap;
  logic             restart;

  for (genvar g = 0; g < 8; g++) begin : g_tab
    assign div_tab[g] =
      CNT_W'(baud_div(CLK_HZ, 3'(g)) - 1);
  end

  assign wrap    = (cnt == div_tab[sel]);
  assign restart = (sel != sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      sel_q <= 3'd0;
      tick  <= 1'b0;
    end else begin
      sel_q <= sel;
      tick  <= wrap & ~restart;
      if (wrap || restart) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_trx_param.sv
// uart_trx_param: full-duplex UART, DATA_W bits, runtime parity
// and stop config, 16x oversampled majority-vote receiver.
// Ports: clk/reset; baud_select, parity_mode, two_stop,
// loopback; Tx_EN/Tx_WR/Tx_DATA -> Tx_BUSY/TxD;
// RxD/Rx_EN -> Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR.
module uart_trx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        baud_select,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic              loopback,
  input  logic              Tx_EN,
  input  logic              Tx_WR,
  input  logic [DATA_W-1:0] Tx_DATA,
  output logic              Tx_BUSY,
  output logic              TxD,
  input  logic              RxD,
  input  logic              Rx_EN,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  output logic              Rx_PERROR,
  output logic              Rx_FERROR
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

  logic tick;

  uart_baud_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .sel   (baud_select),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e         tx_state, tx_state_nx;
  logic              tx_go, tx_go_nx;
  logic [3:0]        tx_tcnt, tx_tcnt_nx;
  logic [3:0]        tx_bcnt, tx_bcnt_nx;
  logic [DATA_W-1:0] tx_shift, tx_shift_nx;
  logic              tx_par, tx_par_nx;
  logic              tx_pen, tx_pen_nx;
  logic              tx_two, tx_two_nx;
  logic              tx_stop2, tx_stop2_nx;
  logic              txd_nx;
  logic              tx_last;

  assign Tx_BUSY = (tx_state != TX_IDLE);
  assign tx_last = (tx_tcnt == 4'd15);

  always_comb begin
    tx_state_nx = tx_state;
    tx_go_nx    = tx_go;
    tx_tcnt_nx  = tx_tcnt;
    tx_bcnt_nx  = tx_bcnt;
    tx_shift_nx = tx_shift;
    tx_par_nx   = tx_par;
    tx_pen_nx   = tx_pen;
    tx_two_nx   = tx_two;
    tx_stop2_nx = tx_stop2;
    txd_nx      = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        if (Tx_WR && Tx_EN) begin
          tx_state_nx = TX_START;
          tx_go_nx    = 1'b0;
          tx_tcnt_nx  = 4'd0;
          tx_shift_nx = Tx_DATA;
          tx_pen_nx   = (parity_mode == PAR_EVEN) |
                        (parity_mode == PAR_ODD);
          tx_par_nx   = (^Tx_DATA) ^
                        (parity_mode == PAR_ODD);
          tx_two_nx   = two_stop;
        end
      end
      TX_START: begin
        // First tick only aligns the frame to the tick grid.
        if (tick) begin
          if (!tx_go) begin
            tx_go_nx = 1'b1;
          end else begin
            tx_tcnt_nx = tx_tcnt + 4'd1;
            if (tx_last) begin
              tx_state_nx = TX_DATA;
              tx_bcnt_nx  = 4'd0;
            end
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tcnt_nx = tx_tcnt + 4'd1;
          if (tx_last) begin
            tx_shift_nx = tx_shift >> 1;
            if (tx_bcnt == BIT_LAST) begin
              tx_state_nx = tx_pen ? TX_PARITY : TX_STOP;
              tx_stop2_nx = 1'b0;
            end else begin
              tx_bcnt_nx = tx_bcnt + 4'd1;
            end
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          tx_tcnt_nx = tx_tcnt + 4'd1;
          if (tx_last) begin
            tx_state_nx = TX_STOP;
            tx_stop2_nx = 1'b0;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tcnt_nx = tx_tcnt + 4'd1;
          if (tx_last) begin
            if (tx_two && !tx_stop2) tx_stop2_nx = 1'b1;
            else                     tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    // Line value follows the next state so TxD is a clean flop.
    case (tx_state_nx)
      TX_START:  txd_nx = ~tx_go_nx;
      TX_DATA:   txd_nx = tx_shift_nx[0];
      TX_PARITY: txd_nx = tx_par_nx;
      default:   txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_go    <= 1'b0;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 4'd0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_stop2 <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_go    <= tx_go_nx;
      tx_tcnt  <= tx_tcnt_nx;
      tx_bcnt  <= tx_bcnt_nx;
      tx_shift <= tx_shift_nx;
      tx_par   <= tx_par_nx;
      tx_pen   <= tx_pen_nx;
      tx_two   <= tx_two_nx;
      tx_stop2 <= tx_stop2_nx;
      TxD      <= txd_nx;
    end
  end

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0],
                  loopback ? TxD : RxD};
  end

  assign rxs = sync[SYNC_STAGES-1];

  rx_state_e         rx_state, rx_state_nx;
  logic [3:0]        rx_tcnt, rx_tcnt_nx;
  logic [3:0]        rx_bcnt, rx_bcnt_nx;
  logic [1:0]        rx_samp, rx_samp_nx;
  logic [DATA_W-1:0] rx_shift, rx_shift_nx;
  logic              rx_perr, rx_perr_nx;
  logic              rx_ferr, rx_ferr_nx;
  logic              rx_armed, rx_armed_nx;
  logic              rx_pen, rx_pen_nx;
  logic              rx_odd, rx_odd_nx;
  logic              rx_two, rx_two_nx;
  logic              rx_stop2, rx_stop2_nx;
  logic [DATA_W-1:0] rx_data_nx;
  logic              rx_valid_nx;
  logic              rx_perr_o_nx;
  logic              rx_ferr_o_nx;
  logic              rx_mid, rx_end, bit_val;
  logic              ferr_acc;

  assign rx_mid  = tick & (rx_tcnt == 4'd9);
  assign rx_end  = tick & (rx_tcnt == 4'd15);
  assign bit_val = maj3(rx_samp[0], rx_samp[1], rxs);

  always_comb begin
    rx_state_nx  = rx_state;
    rx_tcnt_nx   = rx_tcnt;
    rx_bcnt_nx   = rx_bcnt;
    rx_samp_nx   = rx_samp;
    rx_shift_nx  = rx_shift;
    rx_perr_nx   = rx_perr;
    rx_ferr_nx   = rx_ferr;
    rx_armed_nx  = rx_armed;
    rx_pen_nx    = rx_pen;
    rx_odd_nx    = rx_odd;
    rx_two_nx    = rx_two;
    rx_stop2_nx  = rx_stop2;
    rx_data_nx   = Rx_DATA;
    rx_valid_nx  = Rx_VALID;
    rx_perr_o_nx = Rx_PERROR;
    rx_ferr_o_nx = Rx_FERROR;
    ferr_acc     = rx_ferr | ~bit_val;
    if (tick && rx_state != RX_IDLE) begin
      rx_tcnt_nx = rx_tcnt + 4'd1;
      if (rx_tcnt == 4'd7) rx_samp_nx[0] = rxs;
      if (rx_tcnt == 4'd8) rx_samp_nx[1] = rxs;
    end
    if (!Rx_EN) begin
      rx_state_nx  = RX_IDLE;
      rx_tcnt_nx   = 4'd0;
      rx_armed_nx  = rxs;
      rx_valid_nx  = 1'b0;
      rx_perr_o_nx = 1'b0;
      rx_ferr_o_nx = 1'b0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          // A held-low line (break) never re-arms the receiver.
          rx_tcnt_nx  = 4'd0;
          rx_armed_nx = rx_armed | rxs;
          if (rx_armed && !rxs) begin
            rx_state_nx = RX_START;
            rx_armed_nx = 1'b0;
            rx_pen_nx   = (parity_mode == PAR_EVEN) |
                          (parity_mode == PAR_ODD);
            rx_odd_nx   = (parity_mode == PAR_ODD);
            rx_two_nx   = two_stop;
          end
        end
        RX_START: begin
          if (rx_mid) begin
            if (bit_val) begin
              rx_state_nx = RX_IDLE;
            end else begin
              rx_perr_nx   = 1'b0;
              rx_ferr_nx   = 1'b0;
              rx_valid_nx  = 1'b0;
              rx_perr_o_nx = 1'b0;
              rx_ferr_o_nx = 1'b0;
            end
          end
          if (rx_end) begin
            rx_state_nx = RX_DATA;
            rx_bcnt_nx  = 4'd0;
          end
        end
        RX_DATA: begin
          if (rx_mid)
            rx_shift_nx = {bit_val, rx_shift[DATA_W-1:1]};
          if (rx_end) begin
            if (rx_bcnt == BIT_LAST) begin
              rx_state_nx = rx_pen ? RX_PARITY : RX_STOP;
              rx_stop2_nx = 1'b0;
            end else begin
              rx_bcnt_nx = rx_bcnt + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_mid)
            rx_perr_nx = bit_val ^ (^rx_shift) ^ rx_odd;
          if (rx_end) begin
            rx_state_nx = RX_STOP;
            rx_stop2_nx = 1'b0;
          end
        end
        RX_STOP: begin
          if (rx_mid) begin
            rx_ferr_nx = ferr_acc;
            // Finish mid-stop so a back-to-back start is caught.
            if (!(rx_two && !rx_stop2)) begin
              rx_state_nx  = RX_IDLE;
              rx_armed_nx  = 1'b0;
              rx_data_nx   = rx_shift;
              rx_valid_nx  = ~rx_perr & ~ferr_acc;
              rx_perr_o_nx = rx_perr;
              rx_ferr_o_nx = ferr_acc;
            end
          end
          if (rx_end && rx_two && !rx_stop2)
            rx_stop2_nx = 1'b1;
        end
        default: rx_state_nx = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      rx_tcnt   <= 4'd0;
      rx_bcnt   <= 4'd0;
      rx_samp   <= 2'b11;
      rx_shift  <= '0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_armed  <= 1'b0;
      rx_pen    <= 1'b0;
      rx_odd    <= 1'b0;
      rx_two    <= 1'b0;
      rx_stop2  <= 1'b0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      rx_tcnt   <= rx_tcnt_nx;
      rx_bcnt   <= rx_bcnt_nx;
      rx_samp   <= rx_samp_nx;
      rx_shift  <= rx_shift_nx;
      rx_perr   <= rx_perr_nx;
      rx_ferr   <= rx_ferr_nx;
      rx_armed  <= rx_armed_nx;
      rx_pen    <= rx_pen_nx;
      rx_odd    <= rx_odd_nx;
      rx_two    <= rx_two_nx;
      rx_stop2  <= rx_stop2_nx;
      Rx_DATA   <= rx_data_nx;
      Rx_VALID  <= rx_valid_nx;
      Rx_PERROR <= rx_perr_o_nx;
      Rx_FERROR <= rx_ferr_o_nx;
    end
  end

endmodule

// File: tb/tb_uart_trx_param.sv
// tb_uart_trx_param: directed + randomized frames checked
// against a bit-level frame model of the UART line format.
module tb_uart_trx_param;

  localparam int unsigned HZ = 50_000_000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'd7;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       loopback = 1'b1;
  logic       Tx_EN = 1'b1;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Tx_BUSY;
  logic       TxD;
  logic       RxD = 1'b1;
  logic       Rx_EN = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_trx_param #(
    .DATA_W      (8),
    .CLK_HZ      (HZ),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .loopback    (loopback),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .Tx_BUSY     (Tx_BUSY),
    .TxD         (TxD),
    .RxD         (RxD),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  // Busy pulse length monitor.
  int busy_run = 0;
  int busy_len = 0;
  always @(negedge clk) begin
    if (Tx_BUSY === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Width of the first TxD low run after meas_en rises.
  logic meas_en = 1'b0;
  logic start_done = 1'b0;
  int   low_cnt = 0;
  int   start_w = 0;
  always @(negedge clk) begin
    if (!meas_en) begin
      low_cnt = 0;
      start_done = 1'b0;
    end else if (!start_done) begin
      if (TxD === 1'b0) low_cnt++;
      else if (low_cnt != 0) begin
        start_w = low_cnt;
        start_done = 1'b1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic int bit_time(input int sel);
    int rates [8];
    int b16;
    rates = '{300, 1200, 4800, 9600, 19200, 38400,
              57600, 115200};
    b16 = 16 * rates[sel];
    return 16 * ((HZ + b16 / 2) / b16);
  endfunction

  // Frame model: bit k of w is the k-th line bit.
  function automatic int build_frame(
    input  logic [7:0]  d,
    input  logic [1:0]  mode,
    input  logic        two,
    output logic [15:0] w
  );
    int n;
    w = '1;
    w[0] = 1'b0;
    for (int i = 0; i < 8; i++) w[1+i] = d[i];
    n = 9;
    if (mode == 2'b01 || mode == 2'b10) begin
      w[n] = ($countones(d) % 2 == 1) ^ (mode == 2'b10);
      n++;
    end
    n += two ? 2 : 1;
    return n;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int t;
    for (t = 0; t < lim && Tx_BUSY !== 1'b0; t++)
      @(negedge clk);
    check({tag, "_idle"}, Tx_BUSY, 1'b0);
  endtask

  task automatic write(input logic [7:0] d);
    @(negedge clk);
    Tx_DATA = d;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic tx_loop(
    input  logic [7:0]  d,
    input  logic [1:0]  mode,
    input  logic        two,
    input  string       tag,
    output logic [15:0] w
  );
    logic [15:0] e;
    int n, bt, t;
    bt = bit_time(7);
    n = build_frame(d, mode, two, e);
    @(negedge clk);
    parity_mode = mode;
    two_stop = two;
    write(d);
    w = '1;
    for (t = 0; t < 20000 && TxD !== 1'b0; t++)
      @(negedge clk);
    check({tag, "_start"}, TxD, 1'b0);
    repeat (bt / 2) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      w[k] = TxD;
      if (k != n - 1) repeat (bt) @(negedge clk);
    end
    check({tag, "_frame"}, w, e);
    wait_idle(tag, 3000);
    repeat (5) @(negedge clk);
    check({tag, "_rxdata"}, Rx_DATA, d);
    check({tag, "_rxvalid"}, Rx_VALID, 1'b1);
    check({tag, "_rxerr"}, {Rx_PERROR, Rx_FERROR}, 2'b00);
  endtask

  task automatic drive_rx(
    input logic [15:0] w,
    input int          n
  );
    int bt;
    bt = bit_time(7);
    for (int k = 0; k < n; k++) begin
      RxD = w[k];
      repeat (bt) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] w;
    int n, bt, bad, t;
    bt = bit_time(7);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_txd", TxD, 1'b1);
    check("rst_busy", Tx_BUSY, 1'b0);
    check("rst_rxdata", Rx_DATA, 8'h00);
    check("rst_flags", {Rx_VALID, Rx_PERROR, Rx_FERROR},
          3'b000);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 loopback, start bit width and busy length.
    meas_en = 1'b1;
    tx_loop(8'hA5, 2'b00, 1'b0, "t1", w);
    check("t1_start_w", start_done ? start_w : -1, bt);
    check("t1_busy_len",
          busy_len > 10 * bt && busy_len <= 10 * bt + 29,
          1'b1);
    meas_en = 1'b0;

    // Even / odd parity bit on the line.
    tx_loop(8'h07, 2'b01, 1'b0, "t2e", w);
    check("t2e_parbit", w[9], 1'b1);
    tx_loop(8'h07, 2'b10, 1'b0, "t2o", w);
    check("t2o_parbit", w[9], 1'b0);

    // External line, corrupted parity.
    loopback = 1'b0;
    parity_mode = 2'b01;
    n = build_frame(8'h3C, 2'b01, 1'b0, w);
    w[9] = ~w[9];
    drive_rx(w, n);
    RxD = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_perr", Rx_PERROR, 1'b1);
    check("t3_valid", Rx_VALID, 1'b0);
    check("t3_ferr", Rx_FERROR, 1'b0);
    check("t3_data", Rx_DATA, 8'h3C);

    // Receiver disable clears flags, keeps data.
    Rx_EN = 1'b0;
    repeat (3) @(negedge clk);
    check("en_flags", {Rx_VALID, Rx_PERROR, Rx_FERROR},
          3'b000);
    check("en_data", Rx_DATA, 8'h3C);
    Rx_EN = 1'b1;
    repeat (bt) @(negedge clk);

    // Framing error followed by a 20-bit break.
    n = build_frame(8'h55, 2'b01, 1'b0, w);
    drive_rx(w, n - 1);
    RxD = 1'b0;
    bad = 0;
    for (int c = 0; c < 20 * bt; c++) begin
      if (c >= 2 * bt && Rx_FERROR !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t4_break_held", bad, 0);
    check("t4_ferr", Rx_FERROR, 1'b1);
    check("t4_valid", Rx_VALID, 1'b0);
    check("t4_data", Rx_DATA, 8'h55);
    RxD = 1'b1;
    repeat (2 * bt) @(negedge clk);
    n = build_frame(8'h3C, 2'b01, 1'b0, w);
    drive_rx(w, n);
    repeat (10) @(negedge clk);
    check("t4_rec_data", Rx_DATA, 8'h3C);
    check("t4_rec_flags", {Rx_VALID, Rx_PERROR, Rx_FERROR},
          3'b100);

    // 100-cycle glitch is rejected.
    RxD = 1'b0;
    repeat (100) @(negedge clk);
    RxD = 1'b1;
    repeat (600) @(negedge clk);
    check("t5_glitch", {Rx_VALID, Rx_PERROR, Rx_FERROR},
          3'b100);
    check("t5_glitch_data", Rx_DATA, 8'h3C);

    // Two stop bits.
    loopback = 1'b1;
    tx_loop(8'hFF, 2'b00, 1'b1, "t5s", w);
    check("t5_busy_len",
          busy_len > 11 * bt && busy_len <= 11 * bt + 29,
          1'b1);

    // Slower baud start width, then async reset mid-frame.
    @(negedge clk);
    baud_select = 3'd6;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    meas_en = 1'b1;
    write(8'h01);
    for (t = 0; t < 4000 && !start_done; t++)
      @(negedge clk);
    check("t6_start_w", start_done ? start_w : -1,
          bit_time(6));
    meas_en = 1'b0;
    repeat (500) @(negedge clk);
    check("t6_busy_pre", Tx_BUSY, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_txd", TxD, 1'b1);
    check("t6_rst_busy", Tx_BUSY, 1'b0);
    @(negedge clk);
    check("t6_rst_rxdata", Rx_DATA, 8'h00);
    reset = 1'b0;
    baud_select = 3'd7;
    repeat (10) @(negedge clk);

    // Write while busy is ignored.
    write(8'h5A);
    repeat (1000) @(negedge clk);
    write(8'hC3);
    wait_idle("t6_wr", 6000);
    repeat (300) @(negedge clk);
    check("t6_ign_busy", Tx_BUSY, 1'b0);
    check("t6_ign_data", Rx_DATA, 8'h5A);
    check("t6_ign_valid", Rx_VALID, 1'b1);

    // Tx_EN low blocks acceptance.
    Tx_EN = 1'b0;
    write(8'h99);
    repeat (100) @(negedge clk);
    check("t6_en_block", Tx_BUSY, 1'b0);
    Tx_EN = 1'b1;

    // Randomized loopback frames.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      logic [1:0] m;
      logic       s;
      d = 8'($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      tx_loop(d, m, s, $sformatf("rnd%0d", i), w);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
